// File: rtl/obi_a_channel_fifo.sv
// Buffered OBI A-channel front end: decodes and checks each request, then queues it in a
// DEPTH-entry FIFO that the cache controller drains over a valid/ready port.
module obi_a_channel_fifo #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_LSB   = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          obi_req_i,
    output logic                          obi_gnt_o,
    input  logic [31:0]                   obi_addr_i,
    input  logic                          obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]       obi_be_i,
    input  logic [DATA_WIDTH-1:0]         obi_wdata_i,
    input  logic [ID_WIDTH-1:0]           obi_aid_i,
    input  logic                          accept_en_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_we_o,
    output logic [ADDR_WIDTH-1:0]         out_addr_o,
    output logic [DATA_WIDTH/8-1:0]       out_be_o,
    output logic [DATA_WIDTH-1:0]         out_wdata_o,
    output logic [ID_WIDTH-1:0]           out_aid_o,
    output logic                          out_err_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned PtrWidth = $clog2(DEPTH);
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);

    // Masks select the byte-offset bits and the window bits above the word index.
    localparam logic [31:0] LsbMask = (32'h1 << ADDR_LSB) - 32'h1;
    localparam logic [31:0] HiMask  = ~((32'h1 << (ADDR_LSB + ADDR_WIDTH)) - 32'h1);

    logic                  r_we    [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [BeWidth-1:0]    r_be    [DEPTH];
    logic [DATA_WIDTH-1:0] r_wdata [DEPTH];
    logic [ID_WIDTH-1:0]   r_aid   [DEPTH];
    logic                  r_err   [DEPTH];

    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [CntWidth-1:0]   r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign obi_gnt_o   = accept_en_i && !rst && (r_count != CntWidth'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = obi_req_i && obi_gnt_o;
    assign w_pop       = out_valid_o && out_ready_i;

    assign w_err   = ((obi_addr_i & HiMask) != (BASE_ADDR & HiMask)) ||
                     ((obi_addr_i & LsbMask) != 32'h0);
    assign w_wdata = obi_we_i ? obi_wdata_i : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_we[i]    <= 1'b0;
                r_addr[i]  <= '0;
                r_be[i]    <= '0;
                r_wdata[i] <= '0;
                r_aid[i]   <= '0;
                r_err[i]   <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_we[r_wr_ptr]    <= obi_we_i;
                r_addr[r_wr_ptr]  <= obi_addr_i[ADDR_LSB +: ADDR_WIDTH];
                r_be[r_wr_ptr]    <= obi_be_i;
                r_wdata[r_wr_ptr] <= w_wdata;
                r_aid[r_wr_ptr]   <= obi_aid_i;
                r_err[r_wr_ptr]   <= w_err;
                r_wr_ptr          <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_we_o    = r_we[r_rd_ptr];
    assign out_addr_o  = r_addr[r_rd_ptr];
    assign out_be_o    = r_be[r_rd_ptr];
    assign out_wdata_o = r_wdata[r_rd_ptr];
    assign out_aid_o   = r_aid[r_rd_ptr];
    assign out_err_o   = r_err[r_rd_ptr];
    assign count_o     = r_count;

endmodule

// File: tb/tb_obi_a_channel_fifo.sv
// Bench for obi_a_channel_fifo: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model.
module tb_obi_a_channel_fifo;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LSB   = 2;
    localparam logic [31:0] BASE  = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          obi_req;
    logic          obi_gnt;
    logic [31:0]   obi_addr;
    logic          obi_we;
    logic [3:0]    obi_be;
    logic [31:0]   obi_wdata;
    logic [0:0]    obi_aid;
    logic          accept_en;
    logic          out_valid;
    logic          out_ready;
    logic          out_we;
    logic [3:0]    out_addr;
    logic [3:0]    out_be;
    logic [31:0]   out_wdata;
    logic [0:0]    out_aid;
    logic          out_err;
    logic [2:0]    count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    obi_a_channel_fifo #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH),
        .ADDR_LSB(LSB), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
        .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_aid_i(obi_aid),
        .accept_en_i(accept_en),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_we_o(out_we),
        .out_addr_o(out_addr), .out_be_o(out_be), .out_wdata_o(out_wdata),
        .out_aid_o(out_aid), .out_err_o(out_err), .count_o(count)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
        logic        err;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t make_entry();
        ent_t e;
        logic [31:0] a;
        a       = obi_addr;
        e.we    = obi_we;
        e.addr  = a[LSB +: AW];
        e.be    = obi_be;
        e.wdata = obi_we ? obi_wdata : 32'h0;
        e.aid   = obi_aid;
        e.err   = (a[31:LSB+AW] != BASE[31:LSB+AW]) || (a[LSB-1:0] != 0);
        return e;
    endfunction

    function automatic bit model_gnt();
        return accept_en && !rst && (q.size() != DEPTH);
    endfunction

    // Reference model: a plain FIFO queue updated at each clock edge.
    always @(posedge clk) begin
        bit g;
        bit o;
        ent_t e;
        if (rst) begin
            q.delete();
        end else begin
            g = model_gnt();
            o = (q.size() != 0) && out_ready;
            e = make_entry();
            if (o) void'(q.pop_front());
            if (obi_req && g) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        chk("count", 64'(count), 64'(q.size()));
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        chk("gnt", 64'(obi_gnt), 64'(model_gnt()));
        if (q.size() != 0) begin
            chk("head_we", 64'(out_we), 64'(q[0].we));
            chk("head_addr", 64'(out_addr), 64'(q[0].addr));
            chk("head_be", 64'(out_be), 64'(q[0].be));
            chk("head_wdata", 64'(out_wdata), 64'(q[0].wdata));
            chk("head_aid", 64'(out_aid), 64'(q[0].aid));
            chk("head_err", 64'(out_err), 64'(q[0].err));
        end
    end

    // Advance one clock edge; return shortly after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [0:0] aid);
        obi_req   = req;
        obi_we    = we;
        obi_addr  = addr;
        obi_be    = 4'hF;
        obi_wdata = wdata;
        obi_aid   = aid;
    endtask

    initial begin
        rst = 1'b1;
        accept_en = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);

        // Reset with a request pending
        cyc();
        cyc();
        chk("rst_gnt", 64'(obi_gnt), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wdata", 64'(out_wdata), 64'd0);
        rst = 1'b0;
        obi_req = 1'b0;
        #1;
        chk("gnt_after_rst", 64'(obi_gnt), 64'd1);

        // Single write then read
        drive(1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1);
        cyc();
        chk("wr_addr", 64'(out_addr), 64'd2);
        chk("wr_we", 64'(out_we), 64'd1);
        chk("wr_wdata", 64'(out_wdata), 64'hDEAD_BEEF);
        chk("wr_err", 64'(out_err), 64'd0);
        chk("wr_aid", 64'(out_aid), 64'd1);
        drive(1'b1, 1'b0, 32'h0000_000C, 32'h1234_5678, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("rd_addr", 64'(out_addr), 64'd3);
        chk("rd_we", 64'(out_we), 64'd0);
        chk("rd_wdata", 64'(out_wdata), 64'd0);
        chk("rd_count", 64'(count), 64'd1);
        obi_req = 1'b0;
        cyc();
        chk("drained", 64'(count), 64'd0);

        // Fill with backpressure, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'(i * 4), 32'(100 + i), 1'(i));
            cyc();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_gnt", 64'(obi_gnt), 64'd0);
        cyc();
        chk("full_hold", 64'(count), 64'd4);
        obi_req = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 64'(out_wdata), 64'(100 + i));
            cyc();
            if (i == 0) chk("gnt_back", 64'(obi_gnt), 64'd1);
        end
        chk("drain_empty", 64'(count), 64'd0);

        // Steady two-deep occupancy across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'h4, 32'(200 + i), 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 32'h4, 32'(202 + k), 1'b0);
            cyc();
            chk("wrap_count", 64'(count), 64'd2);
            chk("wrap_order", 64'(out_wdata), 64'(201 + k));
        end
        obi_req = 1'b0;
        cyc();
        cyc();

        // Error flagging
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0040, 32'h1, 1'b1);
        cyc();
        drive(1'b1, 1'b1, 32'h0000_0006, 32'h2, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 32'h0000_0004, 32'h3, 1'b1);
        cyc();
        obi_req = 1'b0;
        chk("err_count", 64'(count), 64'd3);
        out_ready = 1'b1;
        chk("err_oow", 64'({out_err, out_aid}), 64'b11);
        cyc();
        chk("err_misal", 64'({out_err, out_aid}), 64'b10);
        cyc();
        chk("err_ok", 64'({out_err, out_aid}), 64'b01);
        cyc();

        // accept_en low still drains; reset discards queued entries
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
            cyc();
        end
        accept_en = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("acc_gnt", 64'(obi_gnt), 64'd0);
        cyc();
        chk("acc_drain1", 64'(count), 64'd1);
        cyc();
        chk("acc_drain0", 64'(count), 64'd0);
        chk("acc_gnt2", 64'(obi_gnt), 64'd0);
        accept_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
        end
        chk("pre_rst_count", 64'(count), 64'd3);
        rst = 1'b1;
        cyc();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        obi_req = 1'b0;
        cyc();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 7) a = {26'h0, 4'($urandom), 2'b00};
            else if (r == 7) a = {26'h0, 4'($urandom), 2'($urandom_range(1, 3))};
            else a = $urandom;
            obi_req   = ($urandom_range(0, 3) != 0);
            obi_we    = 1'($urandom);
            obi_addr  = a;
            obi_be    = 4'($urandom);
            obi_wdata = $urandom;
            obi_aid   = 1'($urandom);
            accept_en = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_a_channel_fifo.md
# obi_a_channel_fifo

- Buffered OBI A-channel front end for the cache interface; accepts OBI requests, decodes and checks the address, and queues each accepted request in a DEPTH-entry FIFO.
- Queued requests go to the controller over a valid/ready port.
- Generalises the single-register A-channel capture: parametrised depth, byte enables, transaction IDs, address-range/alignment error flagging and backpressure-driven grant.
- Sits between the OBI master and the cache controller, with the R-channel responder on the far side.

## Interface
Parameters:
- ADDR_WIDTH, 4: word-index bits forwarded to controller
- DATA_WIDTH, 32: data width; must be a multiple of 8
- ID_WIDTH, 1: OBI aid width
- DEPTH, 4: FIFO entries; power of two, ≥2
- ADDR_LSB, 2: byte-offset bits below the word index; equals log2(DATA_WIDTH/8)
- BASE_ADDR, 32'h0: decoded window base; only bits [31:ADDR_LSB+ADDR_WIDTH] are compared

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- obi_req_i  in  1  OBI request valid
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  32  byte address
- obi_we_i  in  1  1=write, 0=read
- obi_be_i  in  DATA_WIDTH/8  byte enables
- obi_wdata_i  in  DATA_WIDTH  write data
- obi_aid_i  in  ID_WIDTH  transaction ID
- accept_en_i  in  1  internal permission to grant; gates obi_gnt_o
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  controller consumes head
- out_we_o  out  1  head write flag
- out_addr_o  out  ADDR_WIDTH  head word index = obi_addr_i[ADDR_LSB +: ADDR_WIDTH]
- out_be_o  out  DATA_WIDTH/8  head byte enables
- out_wdata_o  out  DATA_WIDTH  head write data
- out_aid_o  out  ID_WIDTH  head ID
- out_err_o  out  1  head decode error
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- obi_gnt_o = accept_en_i && (count != DEPTH). This is combinational from registered state only. There is no path from out_ready_i.
- Push when obi_req_i && obi_gnt_o. The entry stores {we, addr index, be, wdata, aid, err}.
  - Reads store be = obi_be_i and wdata = 0.
- err = (obi_addr_i[31:ADDR_LSB+ADDR_WIDTH] != BASE_ADDR[31:ADDR_LSB+ADDR_WIDTH]) || (obi_addr_i[ADDR_LSB-1:0] != 0).
  - Errored requests are still granted and queued, so the responder can return err with the matching aid.
  - The controller does not perform the access when out_err_o is set.
- Pop when out_valid_o && out_ready_i. out_valid_o = (count != 0).
- Head fields are driven from storage[rd_ptr] and are stable while out_valid_o && !out_ready_i.
- wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 → 0. count is tracked separately.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any occupancy from 1 to DEPTH-1.
- At full, a push cannot occur (gnt low) even if a pop happens that cycle. Grant reasserts the following cycle.
- At empty, no pop occurs. out_ready_i is ignored.
- obi_req_i held high with gnt low: nothing stored. The master holds its request per OBI.
- accept_en_i low: gnt low irrespective of space. Queued entries still drain.

## Timing
- Reset (rst high at a clock edge) clears pointers, count and all storage. Reset values:
  - out_valid_o = 0, obi_gnt_o = 0 while rst is high, count_o = 0.
  - All out_* data fields = 0.
- The first grant is possible in the cycle after rst deasserts.
- Reset mid-operation discards all queued entries with no pop handshake. Requests presented during the reset cycle are not granted.
- Latency: a request pushed at edge N appears at the head (out_valid_o = 1) after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- count_o updates on the same edge as push/pop.

## Test plan
- Reset/idle: assert rst 2 cycles with obi_req_i=1 → obi_gnt_o=0 during reset, out_valid_o=0, count_o=0, out_wdata_o=0; gnt=1 on the first cycle after release with accept_en_i=1.
- Single write then read, BASE=0: write addr 32'h0000_0008, be=4'hF, wdata=32'hDEAD_BEEF, aid=1 → next cycle out_addr_o=2, out_we_o=1, out_wdata_o=32'hDEAD_BEEF, out_err_o=0. Then read addr 32'h0000_000C → out_addr_o=3, out_we_o=0, out_wdata_o=0.
- Fill/backpressure: out_ready_i=0, push 4 requests → count_o=4, obi_gnt_o=0 on the fifth. Drain with out_ready_i=1 → entries emerge in order, count decrements to 0, gnt reasserts one cycle after the first pop.
- Wrap-around and simultaneous push/pop: keep count=2 while pushing and popping every cycle for 10 cycles with incrementing wdata → output order matches input order across pointer wrap; count_o stays 2.
- Errors: addr 32'h0000_0040 (out of window) and 32'h0000_0006 (misaligned) → both granted, out_err_o=1 with the correct aid. Addr 32'h0000_0004 → out_err_o=0.
- accept_en_i and reset mid-operation: accept_en_i=0 with 2 queued entries → gnt=0 while the entries still drain. Then with 3 queued entries, assert rst → the next cycle shows count_o=0, out_valid_o=0.
